// File: rtl/tri_bus_port.sv
// Half-duplex endpoint for a shared tri1 data bus.
// Drives words with turnaround guards and captures far-end strobes.
module tri_bus_port #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 2,
    parameter int GUARD = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] tx_data,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_err,
    inout  wire  [WIDTH-1:0] bus_data,
    output logic             bus_oe,
    output logic             bus_stb_o,
    input  logic             bus_stb_i,
    input  logic             bus_busy_i
);

    localparam int MAXC = (HOLD > GUARD) ? HOLD : GUARD;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] G_LAST = CW'(GUARD - 1);
    localparam logic [CW-1:0] H_LAST = CW'(HOLD - 1);

    typedef enum logic [1:0] {
        IDLE,
        TURN_ON,
        DRIVE,
        TURN_OFF
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            pending;
    logic [WIDTH-1:0] tx_reg;
    logic            free;

    assign free     = !bus_busy_i && !bus_stb_i;
    assign tx_ready = (state == IDLE) && !pending && free;
    assign bus_data = bus_oe ? tx_reg : {WIDTH{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pending   <= 1'b0;
            tx_reg    <= '0;
            bus_oe    <= 1'b0;
            bus_stb_o <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            rx_err    <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            rx_err    <= 1'b0;
            bus_stb_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus_stb_i) begin
                        rx_data  <= bus_data;
                        rx_valid <= 1'b1;
                    end
                    if (tx_valid && tx_ready) begin
                        tx_reg <= tx_data;
                        state  <= TURN_ON;
                        cnt    <= '0;
                    end else if (pending && free) begin
                        pending <= 1'b0;
                        state   <= TURN_ON;
                        cnt     <= '0;
                    end
                end
                TURN_ON: begin
                    if (bus_stb_i) begin
                        rx_data  <= bus_data;
                        rx_valid <= 1'b1;
                    end
                    // Far end grabbed the bus first: back off, keep the word.
                    if (!free) begin
                        pending <= 1'b1;
                        state   <= IDLE;
                        cnt     <= '0;
                    end else if (cnt == G_LAST) begin
                        state     <= DRIVE;
                        cnt       <= '0;
                        bus_oe    <= 1'b1;
                        bus_stb_o <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DRIVE: begin
                    rx_err <= bus_stb_i;
                    if (cnt == H_LAST) begin
                        state  <= TURN_OFF;
                        cnt    <= '0;
                        bus_oe <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                TURN_OFF: begin
                    rx_err <= bus_stb_i;
                    if (cnt == G_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule
